// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end for a single shared combinational ALU.
// One operation in flight: IDLE (grant/accept) -> EXEC (drive ALU, capture) -> RESP (hold until taken).
module alu_arbiter #(
    parameter int INPUT_WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [1:0]               req_valid,
    output logic [1:0]               req_ready,
    input  logic [2*INPUT_WIDTH-1:0] req_a,
    input  logic [2*INPUT_WIDTH-1:0] req_b,
    input  logic [7:0]               req_cop,
    output logic [INPUT_WIDTH-1:0]   alu_a,
    output logic [INPUT_WIDTH-1:0]   alu_b,
    output logic [3:0]               alu_cop,
    input  logic [INPUT_WIDTH-1:0]   alu_result,
    input  logic                     alu_ovf,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic                     rsp_id,
    output logic [INPUT_WIDTH-1:0]   rsp_result,
    output logic                     rsp_ovf,
    output logic                     rsp_err,
    output logic                     busy
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    typedef struct packed {
        logic [INPUT_WIDTH-1:0] a;
        logic [INPUT_WIDTH-1:0] b;
        logic [3:0]             cop;
        logic                   id;
    } op_t;

    state_t state, state_nxt;
    op_t    op_q, op_sel;
    logic   ptr;
    logic   any_vld;
    logic   gnt;
    logic   accept;
    logic   cop_ok;
    logic   drive;

    assign any_vld = |req_valid;
    // Pointer holder wins a tie; otherwise whoever is asking.
    assign gnt     = req_valid[ptr] ? ptr : ~ptr;
    assign accept  = (state == IDLE) && any_vld;

    always_comb begin
        op_sel.a   = gnt ? req_a[2*INPUT_WIDTH-1:INPUT_WIDTH] : req_a[INPUT_WIDTH-1:0];
        op_sel.b   = gnt ? req_b[2*INPUT_WIDTH-1:INPUT_WIDTH] : req_b[INPUT_WIDTH-1:0];
        op_sel.cop = gnt ? req_cop[7:4] : req_cop[3:0];
        op_sel.id  = gnt;
    end

    always_comb begin
        case (op_q.cop)
            4'b0000, 4'b0001, 4'b0010,
            4'b0011, 4'b0100, 4'b0110: cop_ok = 1'b1;
            default:                   cop_ok = 1'b0;
        endcase
    end

    // Illegal opcodes never reach the ALU; it keeps seeing all-zero inputs.
    assign drive   = (state == EXEC) && cop_ok;
    assign alu_a   = drive ? op_q.a   : '0;
    assign alu_b   = drive ? op_q.b   : '0;
    assign alu_cop = drive ? op_q.cop : 4'b0000;

    always_comb begin
        state_nxt = state;
        req_ready = 2'b00;
        case (state)
            IDLE: begin
                if (any_vld) begin
                    req_ready[gnt] = 1'b1;
                    state_nxt      = EXEC;
                end
            end
            EXEC:    state_nxt = RESP;
            RESP:    if (rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q <= '0;
        end else if (accept) begin
            op_q <= op_sel;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_result <= '0;
            rsp_ovf    <= 1'b0;
            rsp_err    <= 1'b0;
            rsp_id     <= 1'b0;
        end else if (state == EXEC) begin
            rsp_result <= cop_ok ? alu_result : '0;
            rsp_ovf    <= cop_ok & alu_ovf;
            rsp_err    <= ~cop_ok;
            rsp_id     <= op_q.id;
        end
    end

    // Next round starts with the requester that did not just finish.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= 1'b0;
        end else if ((state == RESP) && rsp_ready) begin
            ptr <= ~rsp_id;
        end
    end

    assign rsp_valid = (state == RESP);
    assign busy      = (state != IDLE);

endmodule
